// File: rtl/multdiv_seq_if.sv
// Handshake and data bundle between the execute-stage control and the iterative
// multiply/divide unit.
interface multdiv_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_seq.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit, one bit per
// clock on operand magnitudes, with sign and overflow fixed up at completion.
module multdiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    multdiv_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [2*WIDTH-1:0] MIN_MAG = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    // r_hi/r_lo hold {partial product, multiplier} or {remainder, dividend/quotient}
    logic [WIDTH-1:0] r_hi, r_lo, r_opb, w_hi_nxt, w_lo_nxt, w_opb_nxt;
    logic             r_sign, r_dz, w_sign_nxt, w_dz_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_ex, r_rdy, r_busy, w_ex_nxt, w_rdy_nxt, w_busy_nxt;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_prod, w_mul_signed;
    logic               w_mul_ovf;
    logic [WIDTH:0]     w_div_sh, w_div_sub;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem, w_div_quo, w_div_signed;
    logic               w_last;

    // Widened by one bit so that the most negative value negates without wrap.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] ext;
        ext = {v[WIDTH-1], v};
        if (v[WIDTH-1]) ext = -ext;
        return ext[WIDTH-1:0];
    endfunction

    assign w_mul_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_mul_prod   = {w_mul_sum, r_lo[WIDTH-1:1]};
    assign w_mul_signed = r_sign ? -w_mul_prod : w_mul_prod;
    assign w_mul_ovf    = r_sign ? (w_mul_prod > MIN_MAG) : (w_mul_prod >= MIN_MAG);

    assign w_div_sh     = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge     = w_div_sh >= {1'b0, r_opb};
    assign w_div_sub    = w_div_sh - {1'b0, r_opb};
    assign w_div_rem    = w_div_ge ? w_div_sub[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
    assign w_div_quo    = {r_lo[WIDTH-2:0], w_div_ge};
    assign w_div_signed = r_sign ? -w_div_quo : w_div_quo;

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_opb_nxt    = r_opb;
        w_sign_nxt   = r_sign;
        w_dz_nxt     = r_dz;
        w_result_nxt = r_result;
        w_ex_nxt     = r_ex;
        w_rdy_nxt    = 1'b0;
        w_busy_nxt   = r_busy;

        unique case (r_state)
            S_IDLE: begin
                if (bus.ctrl_MULT ^ bus.ctrl_DIV) begin
                    w_cnt_nxt  = '0;
                    w_hi_nxt   = '0;
                    w_sign_nxt = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                    w_busy_nxt = 1'b1;
                    if (bus.ctrl_MULT) begin
                        w_lo_nxt    = magnitude(bus.data_operandB);
                        w_opb_nxt   = magnitude(bus.data_operandA);
                        w_dz_nxt    = 1'b0;
                        w_state_nxt = S_MULT;
                    end else begin
                        w_lo_nxt    = magnitude(bus.data_operandA);
                        w_opb_nxt   = magnitude(bus.data_operandB);
                        w_dz_nxt    = (bus.data_operandB == '0);
                        w_state_nxt = S_DIV;
                    end
                end
            end
            S_MULT: begin
                {w_hi_nxt, w_lo_nxt} = w_mul_prod;
                w_cnt_nxt            = r_cnt + CW'(1);
                if (w_last) begin
                    w_result_nxt = w_mul_signed[WIDTH-1:0];
                    w_ex_nxt     = w_mul_ovf;
                    w_rdy_nxt    = 1'b1;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DIV: begin
                if (r_dz) begin
                    w_result_nxt = '0;
                    w_ex_nxt     = 1'b1;
                    w_rdy_nxt    = 1'b1;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_hi_nxt  = w_div_rem;
                    w_lo_nxt  = w_div_quo;
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (w_last) begin
                        // Only -2^31 / -1 yields a positive quotient with the top bit set.
                        w_result_nxt = w_div_signed;
                        w_ex_nxt     = !r_sign && w_div_quo[WIDTH-1];
                        w_rdy_nxt    = 1'b1;
                        w_state_nxt  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_sign   <= 1'b0;
            r_dz     <= 1'b0;
            r_result <= '0;
            r_ex     <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_opb    <= w_opb_nxt;
            r_sign   <= w_sign_nxt;
            r_dz     <= w_dz_nxt;
            r_result <= w_result_nxt;
            r_ex     <= w_ex_nxt;
            r_rdy    <= w_rdy_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_ex;
    assign bus.data_resultRDY = r_rdy;
    assign bus.busy           = r_busy;
endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: directed vector table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
module tb_multdiv_seq;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    multdiv_seq_if #(.WIDTH(32)) bus ();
    multdiv_seq #(.WIDTH(32)) dut (.clock(clk), .reset(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_ex;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference computed directly from signed integer arithmetic.
    task automatic ref_model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output logic e, output int lat);
        longint sa, sb, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            q   = sa * sb;
            r   = q[31:0];
            e   = (q > 64'sd2147483647) || (q < -64'sd2147483648);
            lat = 32;
        end else if (b == 32'd0) begin
            r   = 32'd0;
            e   = 1'b1;
            lat = 1;
        end else begin
            q   = sa / sb;
            r   = q[31:0];
            e   = (q > 64'sd2147483647);
            lat = 32;
        end
    endtask

    // Starts one operation, scrambles the operand inputs after E0, optionally pulses
    // ctrl_DIV mid-operation, and checks result, latency, RDY width and hold.
    task automatic run_op(input string tag, input logic is_div, input logic [31:0] a,
                          input logic [31:0] b, input int pulse_at, input logic [31:0] exp_res,
                          input logic exp_ex, input int exp_lat);
        int lat;
        lat = 0;
        @(negedge clk);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = !is_div;
        bus.ctrl_DIV      = is_div;
        @(posedge clk);
        @(negedge clk);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        check({tag, " busy after E0"}, 64'(bus.busy), 64'd1);
        for (int n = 1; n <= 100; n++) begin
            if (n == pulse_at) bus.ctrl_DIV = 1'b1;
            else if (n == pulse_at + 1) bus.ctrl_DIV = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (bus.data_resultRDY) begin
                lat = n;
                break;
            end
        end
        bus.ctrl_DIV = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, 64'(bus.data_result), 64'(exp_res));
        check({tag, " exception"}, 64'(bus.data_exception), 64'(exp_ex));
        check({tag, " busy in RDY cycle"}, 64'(bus.busy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check({tag, " RDY one cycle"}, 64'(bus.data_resultRDY), 64'd0);
        check({tag, " busy released"}, 64'(bus.busy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, " result held"}, 64'(bus.data_result), 64'(exp_res));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'($urandom_range(0, 40)) - 32'd20;
            4:       return 32'($urandom_range(0, 32'h0001_FFFF)) - 32'h0001_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        logic        e;
        int          lat;
        logic        rdy_seen;
        logic        busy_seen;

        n_cmp  = 0;
        n_fail = 0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset result", 64'(bus.data_result), 64'd0);
        check("reset exception", 64'(bus.data_exception), 64'd0);
        check("reset rdy", 64'(bus.data_resultRDY), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;

        vecs.push_back('{"mul 7*-6",          1'b0, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 32});
        vecs.push_back('{"mul 2^16*2^16",     1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 32});
        vecs.push_back('{"mul min*1",         1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, 32});
        vecs.push_back('{"mul min*-1",        1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32});
        vecs.push_back('{"mul -2^16*2^15",    1'b0, 32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, 32});
        vecs.push_back('{"div -17/5",         1'b1, 32'hFFFF_FFEF, 32'd5,         32'hFFFF_FFFD, 1'b0, 32});
        vecs.push_back('{"div min/-1",        1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32});
        vecs.push_back('{"div 5/7",           1'b1, 32'd5,         32'd7,         32'h0000_0000, 1'b0, 32});
        vecs.push_back('{"div 100/0",         1'b1, 32'd100,       32'd0,         32'h0000_0000, 1'b1, 1});
        vecs.push_back('{"div min/1",         1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, 32});
        vecs.push_back('{"div max/-1",        1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32});
        vecs.push_back('{"div min/min",       1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 1'b0, 32});

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].is_div, vecs[i].a, vecs[i].b, -1,
                   vecs[i].exp_res, vecs[i].exp_ex, vecs[i].exp_lat);

        // Reset in the middle of a divide: no RDY, outputs cleared, unit reusable.
        @(negedge clk);
        bus.data_operandA = 32'd1000;
        bus.data_operandB = 32'd3;
        bus.ctrl_DIV      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ctrl_DIV = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort result", 64'(bus.data_result), 64'd0);
        check("abort exception", 64'(bus.data_exception), 64'd0);
        rdy_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.data_resultRDY) rdy_seen = 1'b1;
        end
        check("abort no rdy", 64'(rdy_seen), 64'd0);
        run_op("mul 3*4 after abort", 1'b0, 32'd3, 32'd4, -1, 32'd12, 1'b0, 32);

        // ctrl_DIV pulsed mid-multiply must be ignored.
        ref_model(1'b0, 32'd123456, 32'hFFFF_FC18, r, e, lat);
        run_op("mul with div pulse", 1'b0, 32'd123456, 32'hFFFF_FC18, 5, r, e, lat);

        // Both controls high in IDLE: no start.
        @(negedge clk);
        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'd3;
        bus.ctrl_MULT     = 1'b1;
        bus.ctrl_DIV      = 1'b1;
        rdy_seen  = 1'b0;
        busy_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.data_resultRDY) rdy_seen = 1'b1;
            if (bus.busy) busy_seen = 1'b1;
        end
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        check("both ctrl no busy", 64'(busy_seen), 64'd0);
        check("both ctrl no rdy", 64'(rdy_seen), 64'd0);
        check("both ctrl result held", 64'(bus.data_result), 64'(r));

        // Randomized operations against the reference model.
        for (int k = 0; k < 40; k++) begin
            logic        op;
            logic [31:0] a, b;
            op = 1'($urandom_range(0, 1));
            a  = pick_operand();
            b  = pick_operand();
            ref_model(op, a, b, r, e, lat);
            run_op($sformatf("rand%0d %s %h,%h", k, op ? "div" : "mul", a, b), op, a, b, -1, r, e, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
